mdu_unit: RTL and testbench

- Multiply/divide unit for the P7 five-stage MIPS pipeline; sits in the E stage beside the ALU.
- Executes mult, multu, div and divu over several cycles, and holds the architectural HI/LO registers.
- Executes mthi, mtlo, mfhi and mflo.
- Drives Busy to the hazard/stall unit, which stalls any MD-class instruction in D while Start or Busy is high.
- Accepts the CP0 exception/interrupt request Req, so an instruction flushed from E never modifies HI/LO.

---
 rtl/mdu_unit.sv | 99 +++++++++
 tb/tb_mdu_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] Out
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_cnt, r_hi, r_lo, r_hi_tmp, r_lo_tmp;
    logic        r_dz;

    logic        w_is_md, w_start, w_mt_ok, w_is_div;
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_bd, w_q_u, w_r_u, w_abs_a, w_abs_b, w_q_m, w_r_m, w_q_s, w_r_s;
    logic [31:0] w_hi_res, w_lo_res, w_cnt_init;

    assign w_is_md  = (MDUOp >= 4'd1) && (MDUOp <= 4'd4);
    assign w_is_div = (MDUOp == 4'd3) || (MDUOp == 4'd4);
    assign w_start  = Start && !Req && w_is_md && (r_state == IDLE);
    assign w_mt_ok  = !Req && (r_state == IDLE);
    assign Busy     = (r_state == BUSY);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced non-zero so the divider never sees 0; such results are never committed.
    assign w_bd    = (B == 32'd0) ? 32'd1 : B;
    assign w_q_u   = A / w_bd;
    assign w_r_u   = A % w_bd;
    // Signed division on magnitudes; 0x80000000 / -1 naturally yields 0x80000000, rem 0.
    assign w_abs_a = A[31] ? -A : A;
    assign w_abs_b = w_bd[31] ? -w_bd : w_bd;
    assign w_q_m   = w_abs_a / w_abs_b;
    assign w_r_m   = w_abs_a % w_abs_b;
    assign w_q_s   = (A[31] ^ w_bd[31]) ? -w_q_m : w_q_m;
    assign w_r_s   = A[31] ? -w_r_m : w_r_m;

    assign w_hi_res   = (MDUOp == 4'd1) ? w_prod_s[63:32] :
                        (MDUOp == 4'd2) ? w_prod_u[63:32] :
                        (MDUOp == 4'd3) ? w_r_s : w_r_u;
    assign w_lo_res   = (MDUOp == 4'd1) ? w_prod_s[31:0] :
                        (MDUOp == 4'd2) ? w_prod_u[31:0] :
                        (MDUOp == 4'd3) ? w_q_s : w_q_u;
    assign w_cnt_init = w_is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);

    // Read port shows architectural HI/LO only, never the pending results.
    assign Out = (MDUOp == 4'd7) ? r_hi : (MDUOp == 4'd8) ? r_lo : 32'd0;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: enter BUSY on an accepted start, leave on the last counted cycle.
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_start)            w_next = BUSY;
        else if (r_state == BUSY && r_cnt == 32'd1) w_next = IDLE;
    end

    // Datapath: capture pending results, count down, commit, and handle mthi/mtlo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_dz     <= 1'b0;
        end else if (w_start) begin
            r_hi_tmp <= w_hi_res;
            r_lo_tmp <= w_lo_res;
            r_cnt    <= w_cnt_init;
            r_dz     <= w_is_div && (B == 32'd0);
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 32'd1;
            if (r_cnt == 32'd1 && !r_dz) begin
                r_hi <= r_hi_tmp;
                r_lo <= r_lo_tmp;
            end
        end else if (w_mt_ok && MDUOp == 4'd5) begin
            r_hi <= A;
        end else if (w_mt_ok && MDUOp == 4'd6) begin
            r_lo <= A;
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized self-checking bench for mdu_unit with a behavioural HI/LO model
module tb_mdu_unit;
    logic        clk = 0;
    logic        reset = 0;
    logic [3:0]  MDUOp = 0;
    logic        Start = 0;
    logic [31:0] A = 0, B = 0;
    logic        Req = 0;
    logic        Busy;
    logic [31:0] Out;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start),
        .A(A), .B(B), .Req(Req), .Busy(Busy), .Out(Out)
    );

    always #5 clk = ~clk;

    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd3: if (b != 0) begin p = 64'(sa / sb); m_lo = p[31:0]; p = 64'(sa % sb); m_hi = p[31:0]; end
            4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic rq);
        @(negedge clk);
        MDUOp = op; Start = st; A = a; B = b; Req = rq;
        @(posedge clk);
        #1;
        MDUOp = 0; Start = 0; Req = 0;
    endtask

    task automatic busy_len(output int c);
        c = 0;
        while (Busy === 1'b1 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        MDUOp = 4'd7; #1 hi = Out;
        MDUOp = 4'd8; #1 lo = Out;
        MDUOp = 4'd0;
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        #1;
        n_tests++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        @(negedge clk) reset = 1;
        issue(4'd6, 32'h55, 0, 0, 0);
        issue(4'd3, 32'd100, 32'd7, 1, 0);
        repeat (6) @(posedge clk);
        #1 reset = 0;
        #1;
        n_tests++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%b exp=0", Busy); end
        @(negedge clk) reset = 1;
        m_hi = 0; m_lo = 0;
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
        end
    endtask

    task automatic test_mult;
        logic [31:0] hi, lo;
        int c;
        issue(4'd1, 32'hFFFFFFFE, 32'd3, 1, 0);
        busy_len(c);
        n_tests++;
        if (c != 5) begin n_fail++; $display("FAIL mult_busy_len got=%0d exp=5", c); end
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL mult_signed got=%h_%h exp=ffffffff_fffffffa", hi, lo);
        end
        issue(4'd2, 32'hFFFFFFFE, 32'd3, 1, 0);
        busy_len(c);
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'd2 || lo !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL multu got=%h_%h exp=00000002_fffffffa", hi, lo);
        end
        m_hi = 32'd2; m_lo = 32'hFFFFFFFA;
    endtask

    task automatic test_div;
        logic [31:0] hi, lo;
        int c;
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1, 0);
        busy_len(c);
        n_tests++;
        if (c != 10) begin n_fail++; $display("FAIL div_busy_len got=%0d exp=10", c); end
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_signed got=%h_%h exp=ffffffff_fffffffd", hi, lo);
        end
        issue(4'd5, 32'h1234, 0, 0, 0);
        issue(4'd4, 32'd7, 32'd0, 1, 0);
        busy_len(c);
        n_tests++;
        if (c != 10) begin n_fail++; $display("FAIL divz_busy_len got=%0d exp=10", c); end
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'h1234 || lo !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_by_zero got=%h_%h exp=00001234_fffffffd", hi, lo);
        end
        m_hi = 32'h1234; m_lo = 32'hFFFFFFFD;
    endtask

    task automatic test_mtmf;
        logic [31:0] v;
        @(negedge clk);
        MDUOp = 4'd6; A = 32'hDEADBEEF; #1;
        n_tests++;
        if (Out !== 32'd0) begin n_fail++; $display("FAIL mtlo_out_zero got=%h exp=0", Out); end
        @(posedge clk); #1;
        n_tests++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got=%b exp=0", Busy); end
        MDUOp = 4'd8; #1;
        n_tests++;
        if (Out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mflo got=%h exp=deadbeef", Out); end
        m_lo = 32'hDEADBEEF;
        MDUOp = 4'd7; #1 v = Out;
        n_tests++;
        if (v !== m_hi) begin n_fail++; $display("FAIL mfhi_old got=%h exp=%h", v, m_hi); end
        @(negedge clk);
        MDUOp = 4'd5; A = 32'hCAFEF00D;
        @(posedge clk); #1;
        MDUOp = 4'd7; #1;
        n_tests++;
        if (Out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mfhi_new got=%h exp=cafef00d", Out); end
        m_hi = 32'hCAFEF00D;
        MDUOp = 0;
    endtask

    task automatic test_req;
        logic [31:0] hi, lo;
        int c;
        issue(4'd1, 32'd3, 32'd4, 1, 1);
        n_tests++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL req_start_busy got=%b exp=0", Busy); end
        issue(4'd5, 32'h77, 0, 0, 1);
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL req_no_change got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo);
        end
        issue(4'd1, 32'd3, 32'd4, 1, 0);
        @(negedge clk);
        @(negedge clk) Req = 1;
        @(negedge clk) Req = 0;
        busy_len(c);
        read_hilo(hi, lo);
        n_tests++;
        if (lo !== 32'd12 || hi !== 32'd0 || c >= 200) begin
            n_fail++; $display("FAIL req_active_completes got=%h_%h exp=00000000_0000000c", hi, lo);
        end
        m_hi = 0; m_lo = 32'd12;
    endtask

    task automatic test_ignore;
        logic [31:0] hi, lo;
        int c;
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1, 0);
        issue(4'd1, 32'd5, 32'd5, 1, 0);
        issue(4'd5, 32'hBAD, 0, 0, 0);
        busy_len(c);
        n_tests++;
        if (c != 8) begin n_fail++; $display("FAIL ignore_busy_len got=%0d exp=8", c); end
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            n_fail++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", hi, lo);
        end
        m_hi = 0; m_lo = 32'h80000000;
        issue(4'd7, 32'd1, 32'd1, 1, 0);
        n_tests++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL start_bad_op got=%b exp=0", Busy); end
    endtask

    task automatic test_random;
        logic [31:0] hi, lo, a, b;
        logic [3:0] op;
        logic st;
        int c, exp_c;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 0;
            if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 7) == 0) b = 32'(int'($urandom_range(0, 20)) - 10);
            st = (op <= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            issue(op, a, b, st, 0);
            model_op(op, a, b);
            exp_c = (op <= 2) ? 5 : (op <= 4) ? 10 : 0;
            busy_len(c);
            n_tests++;
            if (c != exp_c) begin n_fail++; $display("FAIL rand_busy_len[%0d] op=%0d got=%0d exp=%0d", i, op, c, exp_c); end
            read_hilo(hi, lo);
            n_tests++;
            if (hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_mtmf;
        test_req;
        test_ignore;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
